// File: rtl/tick_div_pkg.sv
// Shared types and defaults for the tick divider controller.
package tick_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int DEF_CNT_W = 17;

endpackage

// File: rtl/div_counter.sv
// Loadable up-counter with synchronous clear and a registered terminal-count flag.
module div_counter #(
  parameter int CNT_W = 17
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [CNT_W-1:0] i_ld_val,
  input  logic             i_inc,
  input  logic             i_tc_en,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             r_tc;

  always_comb begin
    w_cnt_nx = r_cnt;
    if (i_clr)
      w_cnt_nx = '0;
    else if (i_ld)
      w_cnt_nx = i_ld_val;
    else if (i_inc)
      w_cnt_nx = r_cnt + CNT_W'(1);
  end

  // The flag reflects the count about to be held, so it is high exactly while the count equals i_last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_tc  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_tc  <= i_tc_en && (w_cnt_nx == i_last);
    end
  end

  assign o_tc = r_tc;

endmodule

// File: rtl/tick_div_ctrl.sv
// Programmable tick divider: IDLE/RUN/PEND FSM with a shadow ratio applied at period boundaries.
// Optional div_clock square-wave output is built only with TICK_DIV_CTRL_PHASE_OUT_EN defined.
module tick_div_ctrl
  import tick_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             div_clock,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_active;
  logic [CNT_W-1:0] r_shadow;
  logic [CNT_W-1:0] w_active_nx;
  logic [CNT_W-1:0] w_shadow_nx;
  logic [CNT_W-1:0] w_ratio;
  logic [CNT_W-1:0] w_last;
  logic             w_acc;
  logic             w_clr;
  logic             w_ld;
  logic             w_inc;
  logic             w_tc_en;
  logic             w_tc;

  assign cfg_ready = (r_state != PEND);
  assign busy      = (r_state != IDLE);
  assign w_acc     = cfg_valid && cfg_ready;
  assign tick      = w_tc;

  always_comb begin
    w_state_nx  = r_state;
    w_active_nx = r_active;
    w_shadow_nx = r_shadow;
    w_ratio     = r_active;
    w_clr       = 1'b0;
    w_ld        = 1'b0;
    w_inc       = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = 1'b1;
        if (w_acc)
          w_active_nx = cfg_div;
        else if (enable && (r_active != '0))
          w_state_nx = RUN;
      end
      default: begin
        if (!enable) begin
          w_state_nx  = IDLE;
          w_shadow_nx = '0;
          w_clr       = 1'b1;
          if (w_acc)
            w_active_nx = cfg_div;
        end else if (w_tc) begin
          // Terminal count: a held or same-cycle ratio takes effect here.
          if (r_state == PEND)
            w_ratio = r_shadow;
          else if (w_acc)
            w_ratio = cfg_div;
          w_active_nx = w_ratio;
          w_shadow_nx = '0;
          w_ld        = 1'b1;
          w_state_nx  = (w_ratio == '0) ? IDLE : RUN;
        end else begin
          w_inc = 1'b1;
          if (w_acc) begin
            w_shadow_nx = cfg_div;
            w_state_nx  = PEND;
          end
        end
      end
    endcase
  end

  assign w_tc_en = (w_state_nx != IDLE);
  assign w_last  = w_active_nx - CNT_W'(1);

  div_counter #(
    .CNT_W (CNT_W)
  ) u_div_counter (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_clr    (w_clr),
    .i_ld     (w_ld),
    .i_ld_val ('0),
    .i_inc    (w_inc),
    .i_tc_en  (w_tc_en),
    .i_last   (w_last),
    .o_tc     (w_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_active <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_active <= w_active_nx;
      r_shadow <= w_shadow_nx;
    end
  end

`ifdef TICK_DIV_CTRL_PHASE_OUT_EN
  logic r_div;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_div <= 1'b0;
    else if (w_state_nx == IDLE)
      r_div <= 1'b0;
    else if (w_tc)
      r_div <= ~r_div;
  end

  assign div_clock = r_div;
`else
  assign div_clock = 1'b0;
`endif

endmodule

// File: tb/tb_tick_div_ctrl.sv
// Self-checking bench for tick_div_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_tick_div_ctrl;

  localparam int W = 17;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         tick;
  logic         div_clock;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: state 0 = stopped, 1 = running, 2 = running with a held ratio.
  int          m_st;
  int unsigned m_n;
  int unsigned m_cnt;
  int unsigned m_sh;
  bit          m_dc;

  always #5 clock = ~clock;

  tick_div_ctrl #(.CNT_W(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .tick      (tick),
    .div_clock (div_clock),
    .busy      (busy)
  );

  function automatic bit exp_tick();
    return (m_st != 0) && (m_n != 0) && (m_cnt == m_n - 1);
  endfunction

  function automatic bit exp_dclk(input bit v);
`ifdef TICK_DIV_CTRL_PHASE_OUT_EN
    return v;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_st = 0; m_n = 0; m_cnt = 0; m_sh = 0; m_dc = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit v, input int unsigned d);
    bit acc;
    int unsigned nn;
    acc = v && (m_st != 2);
    if (m_st == 0) begin
      m_dc = 1'b0;
      if (acc) begin
        m_n = d; m_cnt = 0;
      end else if (en && m_n != 0) begin
        m_st = 1; m_cnt = 0;
      end
    end else if (!en) begin
      m_st = 0; m_cnt = 0; m_dc = 1'b0; m_sh = 0;
      if (acc) m_n = d;
    end else if (m_cnt == m_n - 1) begin
      nn = (m_st == 2) ? m_sh : (acc ? d : m_n);
      m_n = nn; m_cnt = 0; m_dc = ~m_dc; m_sh = 0;
      if (nn == 0) begin
        m_st = 0; m_dc = 1'b0;
      end else begin
        m_st = 1;
      end
    end else begin
      m_cnt++;
      if (acc) begin
        m_sh = d; m_st = 2;
      end
    end
  endtask

  task automatic compare_all();
    chk("tick", tick, exp_tick());
    chk("busy", busy, (m_st != 0));
    chk("cfg_ready", cfg_ready, (m_st != 2));
    chk("div_clock", div_clock, exp_dclk(m_dc));
  endtask

  task automatic step(input bit en, input bit v, input int unsigned d);
    enable = en; cfg_valid = v; cfg_div = W'(d);
    @(posedge clock);
    model_edge(en, v, d);
    @(negedge clock);
    compare_all();
    cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_dclk", div_clock, 0);

    // N=4: ticks on cycles 4, 8, 12 after RUN entry, div_clock period 8.
    step(1, 1, 4);
    step(1, 0, 0);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) step(1, 0, 0);
      chk("n4_tick", tick, (c % 4 == 0));
      chk("n4_busy", busy, 1);
      chk("n4_dclk", div_clock, exp_dclk(((c - 1) / 4) % 2 == 1));
    end

    // Load N=2 mid-period: held until the N=4 boundary.
    step(1, 0, 0);
    step(1, 1, 2);
    chk("pend_ready", cfg_ready, 0);
    step(1, 0, 0);
    chk("pend_ready2", cfg_ready, 0);
    step(1, 0, 0);
    chk("pend_tick_old", tick, 1);
    for (int c = 1; c <= 4; c++) begin
      step(1, 0, 0);
      chk("n2_tick", tick, (c % 2 == 0));
      chk("n2_ready", cfg_ready, 1);
    end

    // Accept at a terminal count applies at once: N=1 ticks every cycle.
    step(1, 1, 1);
    chk("n1_tick0", tick, 1);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0);
      chk("n1_tick", tick, 1);
    end

    // N=3 then load 0: stops at the next terminal count.
    step(1, 1, 3);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("n3_tick", tick, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("z_ready", cfg_ready, 0);
    step(1, 0, 0);
    chk("z_tick", tick, 1);
    step(1, 0, 0);
    chk("z_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      step(1, 0, 0);
      chk("z_notick", tick, 0);
    end

    // N=5 with a held ratio, drop enable, resume at N=5.
    step(1, 1, 5);
    step(1, 0, 0);
    step(1, 1, 3);
    step(0, 0, 0);
    chk("dis_busy", busy, 0);
    chk("dis_ready", cfg_ready, 1);
    step(1, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) step(1, 0, 0);
      chk("re5_tick", tick, (c == 5));
    end

    // Reset at count 3 of N=6.
    step(0, 0, 0);
    step(0, 1, 6);
    step(1, 0, 0);
    for (int c = 0; c < 3; c++) step(1, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("ar_tick", tick, 0);
    chk("ar_busy", busy, 0);
    chk("ar_dclk", div_clock, 0);
    @(negedge clock);
    reset = 1'b0;
    compare_all();
    chk("rel_tick", tick, 0);
    chk("rel_ready", cfg_ready, 1);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clock);
        reset = 1'b0;
        compare_all();
      end else begin
        step($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
